// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared encodings, FSM states and op-class helpers for the
//            multiply/divide unit. MDU_MADD_EN enables madd/maddu (ops 7/8).
// Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // md_op encodings as driven by the decode stage
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    // Ops that occupy the unit for MULT_CYCLES
    function automatic logic is_mult_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_MADD) || (op == MD_MADDU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    // Ops that occupy the unit for DIV_CYCLES
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Any op that takes the unit into BUSY
    function automatic logic is_multi_op(input logic [3:0] op);
        return is_mult_op(op) || is_div_op(op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl_if
// Brief    : EX-stage request / HI-LO result bundle between the pipeline
//            (master) and the multiply/divide controller (slave).
// Revision : 1.0  initial release
// ============================================================================
interface mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             md_use_d;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             stall_req;

    modport master (
        output start, md_op, a, b, md_use_d,
        input  busy, hi, lo, stall_req
    );

    modport slave (
        input  start, md_op, a, b, md_use_d,
        output busy, hi, lo, stall_req
    );
endinterface
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module   : mdu_calc
// Brief    : Combinational result path for the MDU. Produces the next {hi,lo}
//            from the latched op/operands and a write enable that is low for
//            divide by zero. MDU_MADD_EN adds the madd/maddu accumulate path.
// Revision : 1.0  initial release
// ============================================================================
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt,
    output logic             o_we
);
    localparam int               c_dw  = 2 * WIDTH;
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [c_dw-1:0]  w_sprod;
    logic [c_dw-1:0]  w_uprod;
    logic             w_sdiv;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_div_b;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

    // Sign-extending to double width makes the low 2*WIDTH bits of an
    // unsigned multiply equal to the signed product.
    assign w_sprod = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // One unsigned divider serves both div and divu; signed division works on
    // magnitudes and restores signs afterwards, so MIN / -1 yields MIN, rem 0.
    assign w_sdiv  = (i_op == MD_DIV);
    assign w_a_neg = w_sdiv & i_a[WIDTH-1];
    assign w_b_neg = w_sdiv & i_b[WIDTH-1];
    assign w_abs_a = w_a_neg ? (~i_a + c_one) : i_a;
    assign w_abs_b = w_b_neg ? (~i_b + c_one) : i_b;
    // Divisor of zero is never committed; substitute 1 to keep the divider sane.
    assign w_div_b = (w_abs_b == '0) ? c_one : w_abs_b;
    assign w_uq    = w_abs_a / w_div_b;
    assign w_ur    = w_abs_a % w_div_b;
    assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_uq + c_one) : w_uq;
    assign w_r     = w_a_neg ? (~w_ur + c_one) : w_ur;

`ifdef MDU_MADD_EN
    logic [c_dw-1:0] w_acc;
    assign w_acc = {i_hi, i_lo} + ((i_op == MD_MADD) ? w_sprod : w_uprod);
`endif

    // Select the result for the latched op; unknown ops leave HI/LO alone
    always_comb begin
        o_hi_nxt = i_hi;
        o_lo_nxt = i_lo;
        o_we     = 1'b0;
        case (i_op)
            MD_MULT: begin
                {o_hi_nxt, o_lo_nxt} = w_sprod;
                o_we                 = 1'b1;
            end
            MD_MULTU: begin
                {o_hi_nxt, o_lo_nxt} = w_uprod;
                o_we                 = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                o_hi_nxt = w_r;
                o_lo_nxt = w_q;
                o_we     = (i_b != '0);
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: begin
                {o_hi_nxt, o_lo_nxt} = w_acc;
                o_we                 = 1'b1;
            end
`endif
            default: begin
                o_we = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Brief    : EX-stage multiply/divide controller. Latches forwarded operands,
//            sequences a fixed latency, owns HI/LO and requests a pipeline
//            stall when the ID-stage instruction needs the unit while busy.
//            MDU_MADD_EN (see mdu_pkg/mdu_calc) enables madd/maddu.
// Revision : 1.0  initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  md
);
    localparam int c_max_lat = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);
    localparam logic [c_cnt_w-1:0] c_mult_lat = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_lat  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    mdu_state_t         r_state;
    mdu_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_load;
    logic               w_commit;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_busy;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic               w_calc_we;

    assign w_busy = (r_state == ST_BUSY);

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-cycle action decode; start is ignored while busy
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (md.start) begin
                    if (is_multi_op(md.md_op)) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end else if (md.md_op == MD_MTHI) begin
                        w_mthi = 1'b1;
                    end else if (md.md_op == MD_MTLO) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == c_cnt_one) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand/op latches and latency counter; the result only ever sees these
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_op  <= MD_NONE;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_load) begin
            r_cnt <= is_div_op(md.md_op) ? c_div_lat : c_mult_lat;
            r_op  <= md.md_op;
            r_a   <= md.a;
            r_b   <= md.b;
        end else if (w_busy) begin
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    mdu_calc #(
        .WIDTH    (WIDTH)
    ) u_calc (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt),
        .o_we     (w_calc_we)
    );

    // HI/LO: written by a committing operation or directly by mthi/mtlo
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            if (w_calc_we) begin
                r_hi <= w_hi_nxt;
                r_lo <= w_lo_nxt;
            end
        end else begin
            if (w_mthi) r_hi <= md.a;
            if (w_mtlo) r_lo <= md.a;
        end
    end

    assign md.busy      = w_busy;
    assign md.hi        = r_hi;
    assign md.lo        = r_lo;
    assign md.stall_req = (w_busy | (md.start & is_multi_op(md.md_op))) & md.md_use_d;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Brief    : Self-checking bench for mdu_ctrl: directed cases plus random ops
//            against an arithmetic reference of HI/LO. Honours MDU_MADD_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_ctrl;

`ifdef MDU_MADD_EN
    localparam bit c_madd = 1'b1;
`else
    localparam bit c_madd = 1'b0;
`endif
    localparam int c_mult_lat = 5;
    localparam int c_div_lat  = 10;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl_if #(.WIDTH(32)) bus ();

    mdu_ctrl #(
        .WIDTH       (32),
        .MULT_CYCLES (c_mult_lat),
        .DIV_CYCLES  (c_div_lat)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard unit never lets start through while busy
    always @(posedge clk) begin
        if (reset === 1'b1 && bus.busy === 1'b1 && bus.start === 1'b1) begin
            bad++;
            $display("FAIL start_while_busy: start=1 busy=1 at %0t", $time);
        end
    end

    function automatic logic is_multi(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (c_madd && (op == 4'd7 || op == 4'd8));
    endfunction

    function automatic int latency(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return c_mult_lat;
        if (op == 4'd3 || op == 4'd4) return c_div_lat;
        if (c_madd && (op == 4'd7 || op == 4'd8)) return c_mult_lat;
        return 0;
    endfunction

    // Architectural effect of one op on the model HI/LO
    function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int              sa;
        int              sb;
        longint          sp;
        longint unsigned up;
        logic [63:0]     acc;
        sa = $signed(a);
        sb = $signed(b);
        sp = longint'(sa) * longint'(sb);
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1: {m_hi, m_lo} = sp;
            4'd2: {m_hi, m_lo} = up;
            4'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'h0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            4'd7: if (c_madd) begin
                acc = {m_hi, m_lo} + sp;
                {m_hi, m_lo} = acc;
            end
            4'd8: if (c_madd) begin
                acc = {m_hi, m_lo} + up;
                {m_hi, m_lo} = acc;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from just after a negedge; counts busy cycles and any
    // stall_req deviation from its expected value along the way.
    task automatic run_mdu(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                           input logic use_d, output int nbusy, output int stall_bad);
        int guard;
        stall_bad = 0;
        nbusy     = 0;
        guard     = 0;
        bus.start    = 1'b1;
        bus.md_op    = op;
        bus.a        = av;
        bus.b        = bv;
        bus.md_use_d = use_d;
        #1;
        if (bus.stall_req !== (use_d & is_multi(op))) stall_bad++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        #1;
        while (bus.busy === 1'b1 && guard < 200) begin
            if (bus.stall_req !== use_d) stall_bad++;
            nbusy++;
            @(negedge clk);
            bus.a = $urandom;
            bus.b = $urandom;
            #1;
            guard++;
        end
        if (bus.stall_req !== 1'b0) stall_bad++;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.md_op    = 4'd0;
        bus.a        = 32'h0;
        bus.b        = 32'h0;
        bus.md_use_d = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall_req); end
        reset = 1'b1;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        @(negedge clk);
    endtask

    // Directed mult/multu/div/divu cases with spec-derived constants
    task automatic test_arith();
        logic [3:0]  ops [7] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [31:0] av  [7] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'd7, 32'd100};
        logic [31:0] bv  [7] = '{32'd5, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd7};
        logic [31:0] ehi [7] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'd2};
        logic [31:0] elo [7] = '{32'd15, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                                 32'h8000_0000, 32'hFFFF_FFFD, 32'd14};
        int nb;
        int sb;
        for (int i = 0; i < 7; i++) begin
            run_mdu(ops[i], av[i], bv[i], 1'b0, nb, sb);
            model_apply(ops[i], av[i], bv[i]);
            total++; if (nb !== latency(ops[i])) begin bad++; $display("FAIL arith%0d_busy: got %0d want %0d", i, nb, latency(ops[i])); end
            total++; if (bus.hi !== ehi[i]) begin bad++; $display("FAIL arith%0d_hi: got %h want %h", i, bus.hi, ehi[i]); end
            total++; if (bus.lo !== elo[i]) begin bad++; $display("FAIL arith%0d_lo: got %h want %h", i, bus.lo, elo[i]); end
        end
    endtask

    task automatic test_mthi_mtlo();
        int nb;
        int sb;
        run_mdu(4'd5, 32'h0000_ABCD, 32'h0, 1'b1, nb, sb);
        model_apply(4'd5, 32'h0000_ABCD, 32'h0);
        total++; if (bus.hi !== 32'h0000_ABCD) begin bad++; $display("FAIL mthi_hi: got %h want 0000abcd", bus.hi); end
        total++; if (nb !== 0) begin bad++; $display("FAIL mthi_busy: got %0d cycles want 0", nb); end
        total++; if (sb !== 0) begin bad++; $display("FAIL mthi_stall: %0d bad cycles want 0", sb); end
        run_mdu(4'd6, 32'h1357_2468, 32'h0, 1'b0, nb, sb);
        model_apply(4'd6, 32'h1357_2468, 32'h0);
        total++; if (bus.lo !== 32'h1357_2468) begin bad++; $display("FAIL mtlo_lo: got %h want 13572468", bus.lo); end
        total++; if (bus.hi !== 32'h0000_ABCD) begin bad++; $display("FAIL mtlo_hi: got %h want 0000abcd", bus.hi); end
    endtask

    task automatic test_div_zero();
        int nb;
        int sb;
        run_mdu(4'd5, 32'h11, 32'h0, 1'b0, nb, sb);
        run_mdu(4'd6, 32'h22, 32'h0, 1'b0, nb, sb);
        m_hi = 32'h11;
        m_lo = 32'h22;
        run_mdu(4'd4, 32'd7, 32'd0, 1'b0, nb, sb);
        total++; if (nb !== c_div_lat) begin bad++; $display("FAIL divu0_busy: got %0d want %0d", nb, c_div_lat); end
        total++; if (bus.hi !== 32'h11) begin bad++; $display("FAIL divu0_hi: got %h want 00000011", bus.hi); end
        total++; if (bus.lo !== 32'h22) begin bad++; $display("FAIL divu0_lo: got %h want 00000022", bus.lo); end
        run_mdu(4'd3, 32'hFFFF_FFF9, 32'd0, 1'b0, nb, sb);
        total++; if (nb !== c_div_lat) begin bad++; $display("FAIL div0_busy: got %0d want %0d", nb, c_div_lat); end
        total++; if ({bus.hi, bus.lo} !== 64'h11_0000_0022) begin bad++; $display("FAIL div0_hilo: got %h_%h want 00000011_00000022", bus.hi, bus.lo); end
    endtask

    task automatic test_stall();
        int nb;
        int sb;
        run_mdu(4'd3, 32'd100, 32'd9, 1'b1, nb, sb);
        model_apply(4'd3, 32'd100, 32'd9);
        total++; if (sb !== 0) begin bad++; $display("FAIL stall_div: %0d bad cycles want 0", sb); end
        total++; if (nb !== c_div_lat) begin bad++; $display("FAIL stall_div_busy: got %0d want %0d", nb, c_div_lat); end
        total++; if (bus.lo !== 32'd11 || bus.hi !== 32'd1) begin bad++; $display("FAIL stall_div_res: got %h_%h want 00000001_0000000b", bus.hi, bus.lo); end
        run_mdu(4'd2, 32'd6, 32'd7, 1'b1, nb, sb);
        model_apply(4'd2, 32'd6, 32'd7);
        total++; if (sb !== 0) begin bad++; $display("FAIL stall_multu: %0d bad cycles want 0", sb); end
    endtask

    task automatic test_random();
        logic [3:0]  ops [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        logic [3:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic        ud;
        int nb;
        int sb;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 8)];
            av = rand_operand();
            bv = rand_operand();
            ud = 1'($urandom_range(0, 1));
            run_mdu(op, av, bv, ud, nb, sb);
            model_apply(op, av, bv);
            total++; if (nb !== latency(op)) begin bad++; $display("FAIL rnd%0d_busy: op=%0d got %0d want %0d", i, op, nb, latency(op)); end
            total++; if (sb !== 0) begin bad++; $display("FAIL rnd%0d_stall: op=%0d %0d bad cycles", i, op, sb); end
            total++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin
                bad++;
                $display("FAIL rnd%0d_hilo: op=%0d a=%h b=%h got %h_%h want %h_%h", i, op, av, bv, bus.hi, bus.lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_reset_abort();
        int nb;
        int sb;
        run_mdu(4'd5, 32'h1234, 32'h0, 1'b0, nb, sb);
        bus.start    = 1'b1;
        bus.md_op    = 4'd1;
        bus.a        = 32'd3;
        bus.b        = 32'd5;
        bus.md_use_d = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = 4'd0;
        repeat (2) begin
            bus.a = $urandom;
            bus.b = $urandom;
            @(negedge clk);
        end
        bus.a = $urandom;
        bus.b = $urandom;
        #2;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_prebusy: got %b want 1", bus.busy); end
        reset = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++; $display("FAIL abort_hilo: got %h_%h want 0_0", bus.hi, bus.lo); end
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL abort_stall: got %b want 0", bus.stall_req); end
        @(negedge clk);
        reset = 1'b1;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        repeat (12) @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            bad++;
            $display("FAIL abort_nocommit: busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        bus.md_use_d = 1'b0;
    endtask

    task automatic test_madd();
        int nb;
        int sb;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          elat;
        run_mdu(4'd5, 32'h0, 32'h0, 1'b0, nb, sb);
        run_mdu(4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0, nb, sb);
        ehi  = c_madd ? 32'h1 : 32'h0;
        elo  = c_madd ? 32'h0 : 32'hFFFF_FFFF;
        elat = c_madd ? c_mult_lat : 0;
        run_mdu(4'd7, 32'd1, 32'd1, 1'b1, nb, sb);
        total++; if (nb !== elat) begin bad++; $display("FAIL madd_busy: got %0d want %0d", nb, elat); end
        total++; if (bus.hi !== ehi || bus.lo !== elo) begin bad++; $display("FAIL madd_hilo: got %h_%h want %h_%h", bus.hi, bus.lo, ehi, elo); end
        total++; if (sb !== 0) begin bad++; $display("FAIL madd_stall: %0d bad cycles want 0", sb); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_arith();
        test_mthi_mtlo();
        test_div_zero();
        test_stall();
        test_random();
        test_reset_abort();
        test_madd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
